// File: rtl/arb_pkg.sv
// Shared constants for the four-way round-robin mux select arbiter.
package arb_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDXW = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority pick: first set request scanning from start, wrapping mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] start,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [IDXW-1:0] cand;

    // Scan from the far end so the offset closest to start wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDXW'(start + IDXW'(k));
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux41_arbiter.sv
// Round-robin owner of the shared mux41 datapath: registered one-hot grant and
// select, with a bounded hold time while other requesters are pending.
module mux41_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CW       = $clog2(HOLD_MAX)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] sel,
    output logic            busy
);

    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    logic [0:0]      state_q, state_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [IDXW-1:0] sel_q, sel_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] own_mask;
    logic [NREQ-1:0] pick_req;
    logic [IDXW-1:0] pick_start;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    // While owning, the current owner is excluded so the pick finds a successor.
    assign own_mask   = NREQ'(1) << sel_q;
    assign pick_req   = (state_q == ST_OWN) ? (req & ~own_mask) : req;
    assign pick_start = (state_q == ST_OWN) ? IDXW'(sel_q + 1'b1) : IDXW'(last_q + 1'b1);

    rr_pick4 u_pick (
        .req   (pick_req),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 2'b11;
            sel_q   <= 2'b00;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_OWN;
                    last_d  = pick_idx;
                    sel_d   = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                if (!req[sel_q]) begin
                    if (pick_any) begin
                        last_d = pick_idx;
                        sel_d  = pick_idx;
                        gnt_d  = NREQ'(1) << pick_idx;
                        cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if ((cnt_q == CNT_MAX) && pick_any) begin
                    last_d = pick_idx;
                    sel_d  = pick_idx;
                    gnt_d  = NREQ'(1) << pick_idx;
                    cnt_d  = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux41_arbiter.sv
// Directed bench for mux41_arbiter with hand-computed expected grants.
module tb_mux41_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    int total;
    int bad;

    mux41_arbiter #(.HOLD_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b0000;

        // Reset priority: all requesting, requester 0 first.
        do_reset();
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);
        req = 4'b1111;
        tick();
        check("prio_gnt", 32'(gnt), 32'b0001);
        check("prio_sel", 32'(sel), 32'd0);
        check("prio_busy", 32'(busy), 32'd1);

        // Zero-bubble handover 0 -> 2.
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("zb_gnt0", 32'(gnt), 32'b0001);
            check("zb_busy", 32'(busy), 32'd1);
        end
        req = 4'b0100;
        tick();
        check("zb_gnt2", 32'(gnt), 32'b0100);
        check("zb_sel2", 32'(sel), 32'd2);
        check("zb_busy2", 32'(busy), 32'd1);

        // Preemption: 0 and 1 alternate every 8 cycles.
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 32; c++) begin
            tick();
            check("pre_gnt", 32'(gnt), ((c / 8) % 2 == 0) ? 32'b0001 : 32'b0010);
        end

        // Saturation without contention, then release to idle.
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("sat_gnt", 32'(gnt), 32'b1000);
        end
        req = 4'b0000;
        tick();
        check("rel_gnt", 32'(gnt), 32'h0);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_sel", 32'(sel), 32'd3);

        // Fairness wrap: saturated owner 3 is preempted straight to 0.
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 10; c++) tick();
        check("wrap_own3", 32'(gnt), 32'b1000);
        req = 4'b1001;
        tick();
        check("wrap_gnt0", 32'(gnt), 32'b0001);
        check("wrap_sel0", 32'(sel), 32'd0);

        // Async reset between edges while requester 2 owns.
        do_reset();
        req = 4'b0100;
        tick();
        check("ar_own2", 32'(gnt), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gnt", 32'(gnt), 32'h0);
        check("ar_sel", 32'(sel), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        req = 4'b0110;
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_regnt", 32'(gnt), 32'b0010);
        check("ar_resel", 32'(sel), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux41_arbiter.md
# mux41_arbiter

Round-robin arbiter that shares one 4:1 multiplexed datapath among four requesters. It drives the 2-bit select of the `mux41` data mux and a one-hot grant back to the requesters. A grant is held while its requester keeps requesting, up to a bounded number of cycles, and is then handed to the next pending requester in rotation. It sits between the requester ports and the `mux41` select input.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum consecutive cycles one owner may hold the grant while others are pending. Legal range is 2..256.
- `CW`, default `$clog2(HOLD_MAX)`: width of the hold counter. Derived; do not override.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: per-requester request. Bit i is held high for as long as requester i wants the datapath.
- `gnt`, output, 4: one-hot grant, registered. All zeros when idle.
- `sel`, output, 2: index of the current owner, registered. Wired to `mux41.S`.
- `busy`, output, 1: high whenever `gnt != 0`.

## Operation
- Reset values:
  - `gnt` = 4'b0000, `sel` = 2'b00, `busy` = 0.
  - Internal `last` = 2'b11, so requester 0 has first priority.
  - Hold counter = 0. State = IDLE.
- The arbiter has two states, IDLE and OWN.
- Pick function `pick(req, start)`: returns the first index i with `req[i]` set, scanning `start`, `start+1`, ... modulo 4. It also returns `any`.
- IDLE:
  - If `any(req)`: grant `pick(req, last+1)`, go to OWN, clear the counter.
  - Otherwise stay in IDLE.
- OWN, with owner o:
  - **Release.** If `req[o]` = 0: compute `pick(req & ~(1<<o), o+1)`.
    - If some requester is found, grant it immediately with no idle bubble, clear the counter, and stay in OWN.
    - Otherwise go to IDLE and drive `gnt` = 0.
  - **Preempt.** If `req[o]` = 1, the counter equals `HOLD_MAX-1`, and another requester is pending: grant `pick(req & ~(1<<o), o+1)` and clear the counter. The preempted owner re-competes normally.
  - **Hold.** Otherwise keep the grant. The counter increments and saturates at `HOLD_MAX-1` while no one else is pending.
- Every grant change sets `last` to the new owner's index.
- `sel` tracks the owner index. In IDLE, `sel` holds the last owner's value, because `mux41` output is don't-care then.
- `gnt` is always zero or one-hot. Its set bit always equals `1 << sel`.
- Arithmetic: index math is 2-bit and wraps modulo 4. The counter is `CW` bits, unsigned, and never exceeds `HOLD_MAX-1`.
- Reset asserted mid-grant forces all outputs to their reset values immediately, regardless of the clock. The first grant after reset release again favours requester 0.

## Timing
- Grant latency: `req[i]` rising while the arbiter is IDLE produces `gnt[i]` one clock edge later.
- Handover: the owner dropping `req` at edge N has the next owner's `gnt` visible after edge N, with no idle cycle.
- Release to idle: the owner dropping `req` with nothing else pending gives `gnt` = 0 and `busy` = 0 after one edge.
- Maximum hold with contention: the owner keeps `gnt` for exactly `HOLD_MAX` cycles.
- Worst-case wait for any continuously requesting port: 3×`HOLD_MAX` cycles.
- `gnt`, `sel` and `busy` change only on a clock edge or on reset assertion. There are no combinational paths from `req` to any output.

## Structure
Shared package `arb_pkg` holds:
- State encoding localparams `ST_IDLE` and `ST_OWN`.
- `NREQ` = 4.
- `IDXW` = 2.

Sub-module `rr_pick4` is purely combinational:
- Inputs: `req[3:0]`, `start[1:0]`.
- Outputs: `idx[1:0]`, `any`.
- Instantiated once. The top module masks the current owner's bit before passing `req`.

## Test plan
- **Reset priority.** Reset, then `req` = 4'b1111 → `gnt` = 0001 and `sel` = 0 one edge after the first sampling edge.
- **Zero-bubble rotation.** `req` = 4'b0101; requester 0 drops `req` after 3 cycles → the next cycle has `gnt` = 0100 and `sel` = 2, with `busy` never low.
- **Preemption.** `HOLD_MAX` = 8, `req` = 4'b0011 held high → `gnt` alternates 0001 and 0010, each for exactly 8 cycles.
- **Saturation without contention.** `req` = 4'b1000 for 20 cycles → `gnt` = 1000 throughout; then drop it → `gnt` = 0000 and `busy` = 0 one edge later.
- **Fairness wrap.** Owner 3, with `req` = 4'b1001 contending → the next grant goes to 0, not back to 3.
- **Async reset mid-grant.** Assert `rst_n` low between edges while `gnt` = 0100 → `gnt` = 0000 and `sel` = 00 before the next edge. After release with `req` = 4'b0110 → grant goes to requester 1.
